// File: rtl/vga_line_fill_module.sv
// 640x480@60 VGA scan-out from a ping-pong pair of line banks filled one line ahead by an external producer.
// Optional VGA_UNDERRUN_BLACK_EN: blank pixels past the number actually written into the displayed bank.
module vga_line_fill_module #(
  parameter int LINE_W  = 640,
  parameter int TAG_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iEn,
  input  logic [15:0] iData,
  output logic [10:0] oTag,
  output logic        VGA_HSYNC,
  output logic        VGA_VSYNC,
  output logic [15:0] VGAD
);

  localparam int AW = $clog2(LINE_W + 1);
  localparam int IW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int TW = $clog2(TAG_LEN + 1);

  logic [9:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic          bank_sel_q, bank_sel_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [TW-1:0] tag_left_q, tag_left_d;
  logic [9:0]    tag_y_q, tag_y_d;
  logic          act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [15:0]   pix1_q, pix1_d;
  logic [15:0]   vgad_q, vgad_d;
  logic          hs_q, hs_d, vs_q, vs_d;

  logic          req_now, swap_now, req_next;
  logic          wr_en, wr_bank, rd_bank;
  logic [AW-1:0] base_addr;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [9:0]    x_pos;
  logic          h_act, v_act;

  logic [15:0]   bank_mem [2][LINE_W];

`ifdef VGA_UNDERRUN_BLACK_EN
  logic [AW-1:0] fill0_q, fill0_d, fill1_q, fill1_d;
  logic [AW-1:0] rd_fill;
`endif

  always_comb begin
    hcnt_d = (hcnt_q == 10'd799) ? 10'd0 : hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == 10'd799) vcnt_d = (vcnt_q == 10'd524) ? 10'd0 : vcnt_q + 10'd1;

    req_now  = (hcnt_q == 10'd0) && (vcnt_q >= 10'd34) && (vcnt_q <= 10'd513);
    swap_now = (hcnt_q == 10'd0) && (vcnt_q >= 10'd35) && (vcnt_q <= 10'd514);
    // Look one clock ahead so the registered request pulse is high while hcnt==0.
    req_next = (hcnt_d == 10'd0) && (vcnt_d >= 10'd34) && (vcnt_d <= 10'd513);

    tag_left_d = (tag_left_q != '0) ? tag_left_q - TW'(1) : '0;
    tag_y_d    = tag_y_q;
    if (req_next) begin
      tag_left_d = TW'(TAG_LEN);
      tag_y_d    = vcnt_d - 10'd34;
    end

    // A pixel arriving on the swap clock lands in the new write bank.
    bank_sel_d = swap_now ? ~bank_sel_q : bank_sel_q;
    wr_bank    = bank_sel_d;
    rd_bank    = ~bank_sel_q;
    base_addr  = req_now ? '0 : wr_addr_q;
    wr_en      = iEn && (base_addr < AW'(LINE_W));
    wr_addr_d  = wr_en ? base_addr + AW'(1) : base_addr;
    wr_idx     = base_addr[IW-1:0];

    x_pos  = hcnt_q - 10'd144;
    rd_idx = x_pos[IW-1:0];
    h_act  = (hcnt_q >= 10'd144) && (hcnt_q < 10'd784);
    v_act  = (vcnt_q >= 10'd35) && (vcnt_q < 10'd515);
    pix1_d = bank_mem[rd_bank][rd_idx];
    act1_d = h_act && v_act;
    hs1_d  = !(hcnt_q < 10'd96);
    vs1_d  = !(vcnt_q < 10'd2);

`ifdef VGA_UNDERRUN_BLACK_EN
    fill0_d = fill0_q;
    fill1_d = fill1_q;
    if (swap_now) begin
      if (bank_sel_q) fill1_d = wr_addr_q;
      else            fill0_d = wr_addr_q;
    end
    rd_fill = rd_bank ? fill1_q : fill0_q;
    act1_d  = h_act && v_act && (32'(x_pos) < 32'(rd_fill));
`endif

    vgad_d = act1_q ? pix1_q : 16'h0000;
    hs_d   = hs1_q;
    vs_d   = vs1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      bank_sel_q <= 1'b0;
      wr_addr_q  <= '0;
      tag_left_q <= '0;
      tag_y_q    <= '0;
      act1_q     <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      vgad_q     <= 16'h0000;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
`ifdef VGA_UNDERRUN_BLACK_EN
      fill0_q    <= '0;
      fill1_q    <= '0;
`endif
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      bank_sel_q <= bank_sel_d;
      wr_addr_q  <= wr_addr_d;
      tag_left_q <= tag_left_d;
      tag_y_q    <= tag_y_d;
      act1_q     <= act1_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      vgad_q     <= vgad_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
`ifdef VGA_UNDERRUN_BLACK_EN
      fill0_q    <= fill0_d;
      fill1_q    <= fill1_d;
`endif
    end
  end

  // Line banks keep their contents across reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) bank_mem[wr_bank][wr_idx] <= iData;
    pix1_q <= pix1_d;
  end

  assign oTag      = {(tag_left_q != '0), tag_y_q};
  assign VGAD      = vgad_q;
  assign VGA_HSYNC = hs_q;
  assign VGA_VSYNC = vs_q;

endmodule
